// File: rtl/ifu_fetch_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_bridge
//  Description : Bridges the IFU fetch port onto the instruction bus. Fetch
//                PCs become word-aligned bus reads; returned words are queued
//                in an in-order response FIFO whose space is reserved per
//                outstanding read. A flush drops buffered and in-flight words.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_bridge #(
  parameter int PC_W  = 32,
  parameter int IR_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  // IFU fetch request
  input  logic            fch_req_vld,
  output logic            fch_req_rdy,
  input  logic [PC_W-1:0] fch_req_pc,
  // IFU fetch response
  output logic            fch_rsp_vld,
  input  logic            fch_rsp_rdy,
  output logic [IR_W-1:0] fch_rsp_ir,
  // IFU flush
  input  logic            fl_req_vld,
  // Instruction bus request
  output logic            ibus_req_vld,
  input  logic            ibus_req_rdy,
  output logic [PC_W-1:0] ibus_req_addr,
  // Instruction bus response (in order, cannot be stalled)
  input  logic            ibus_rsp_vld,
  input  logic [IR_W-1:0] ibus_rsp_data
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              OCC_W    = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  // Storage and counters
  logic [IR_W-1:0]  fifo_q [DEPTH];
  logic [IR_W-1:0]  fifo_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] live_pend_q, live_pend_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Combinational control
  logic [OCC_W-1:0] occ;
  logic             space;
  logic             hsk;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_live;
  logic             push;

  // The low PC bits are deliberately discarded by word alignment.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fch_req_pc[1:0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Request path: zero-latency pass-through gated by reserved FIFO space
  always_comb begin
    occ           = {1'b0, fcnt_q} + {1'b0, live_pend_q};
    space         = (occ < DEPTH_OCC);
    ibus_req_vld  = ~rst & fch_req_vld & space;
    fch_req_rdy   = ~rst & ibus_req_rdy & space;
    ibus_req_addr = {fch_req_pc[PC_W-1:2], 2'b00};
    hsk           = fch_req_vld & fch_req_rdy;
  end

  // Response path: classify bus returns and present the FIFO head
  always_comb begin
    // Stale reads are always the oldest in flight, so they are retired first.
    rsp_drop    = ibus_rsp_vld & (drop_cnt_q != '0);
    // A return with nothing outstanding is a protocol error and is ignored.
    rsp_live    = ibus_rsp_vld & (drop_cnt_q == '0) & (live_pend_q != '0);
    // A live word returning during a flush is itself stale and never stored.
    push        = rsp_live & ~fl_req_vld;
    fch_rsp_vld = ~rst & (fcnt_q != '0) & ~fl_req_vld;
    fch_rsp_ir  = fifo_q[rd_ptr_q];
    pop         = fch_rsp_vld & fch_rsp_rdy;
  end

  // Next-state computation for FIFO and outstanding-read bookkeeping
  always_comb begin
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fcnt_d      = fcnt_q;
    live_pend_d = live_pend_q;
    drop_cnt_d  = drop_cnt_q;
    if (fl_req_vld) begin
      // Everything live so far becomes stale; a fetch accepted now is the
      // first post-flush read.
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      fcnt_d      = '0;
      drop_cnt_d  = drop_cnt_q + live_pend_q
                    - CNT_W'(rsp_drop) - CNT_W'(rsp_live);
      live_pend_d = hsk ? CNT_W'(1) : '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = ibus_rsp_data;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      fcnt_d      = fcnt_q + CNT_W'(push) - CNT_W'(pop);
      live_pend_d = live_pend_q + CNT_W'(hsk) - CNT_W'(rsp_live);
      drop_cnt_d  = drop_cnt_q - CNT_W'(rsp_drop);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fcnt_q      <= '0;
      live_pend_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fcnt_q      <= fcnt_d;
      live_pend_q <= live_pend_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch_bridge
//  Description : Self-checking bench for ifu_fetch_bridge: request-path
//                vector table plus hand-written multi-cycle sequences, with
//                a scoreboard queue of expected instruction words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_bridge;

  localparam int PC_W  = 32;
  localparam int IR_W  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            fch_req_vld;
  logic            fch_req_rdy;
  logic [PC_W-1:0] fch_req_pc;
  logic            fch_rsp_vld;
  logic            fch_rsp_rdy;
  logic [IR_W-1:0] fch_rsp_ir;
  logic            fl_req_vld;
  logic            ibus_req_vld;
  logic            ibus_req_rdy;
  logic [PC_W-1:0] ibus_req_addr;
  logic            ibus_rsp_vld;
  logic [IR_W-1:0] ibus_rsp_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];

  typedef struct {
    logic        req_vld;
    logic        bus_rdy;
    logic [31:0] pc;
    logic        exp_bvld;
    logic        exp_rdy;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [5];

  ifu_fetch_bridge #(
    .PC_W (PC_W),
    .IR_W (IR_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fch_req_vld  (fch_req_vld),
    .fch_req_rdy  (fch_req_rdy),
    .fch_req_pc   (fch_req_pc),
    .fch_rsp_vld  (fch_rsp_vld),
    .fch_rsp_rdy  (fch_rsp_rdy),
    .fch_rsp_ir   (fch_rsp_ir),
    .fl_req_vld   (fl_req_vld),
    .ibus_req_vld (ibus_req_vld),
    .ibus_req_rdy (ibus_req_rdy),
    .ibus_req_addr(ibus_req_addr),
    .ibus_rsp_vld (ibus_rsp_vld),
    .ibus_rsp_data(ibus_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every delivered word must match the oldest expected word
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (!rst && fch_rsp_vld && fch_rsp_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=%h required=none", fch_rsp_ir);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_word", fch_rsp_ir, e);
      end
    end
    assert (!(ibus_rsp_vld && dut.live_pend_q == 0 && dut.drop_cnt_q == 0))
      else $error("protocol: bus return with nothing outstanding");
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b1, 32'h0000_0004};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0103, 1'b1, 1'b0, 32'h0000_0100};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFC};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0008};
    vecs[4] = '{1'b1, 1'b1, 32'h1234_5677, 1'b1, 1'b1, 32'h1234_5674};

    rst = 1'b1; fch_req_vld = 1'b0; fch_req_pc = '0; fch_rsp_rdy = 1'b1;
    fl_req_vld = 1'b0; ibus_req_rdy = 1'b1; ibus_rsp_vld = 1'b0; ibus_rsp_data = '0;

    // Outputs forced low while in reset
    fch_req_vld = 1'b1;
    #1;
    chk("rst_req_rdy", 32'(fch_req_rdy), 0);
    chk("rst_ibus_vld", 32'(ibus_req_vld), 0);
    chk("rst_rsp_vld", 32'(fch_rsp_vld), 0);
    tick(); tick();
    rst = 1'b0; fch_req_vld = 1'b0;
    chk("rst_fcnt", 32'(dut.fcnt_q), 0);
    chk("rst_live", 32'(dut.live_pend_q), 0);
    chk("rst_drop", 32'(dut.drop_cnt_q), 0);
    chk("rst_rsp_vld_after", 32'(fch_rsp_vld), 0);

    // Request-path vector table (empty bridge, no handshake completes)
    for (int i = 0; i < 5; i++) begin
      fch_req_vld = vecs[i].req_vld; ibus_req_rdy = vecs[i].bus_rdy; fch_req_pc = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_ibus_vld", i), 32'(ibus_req_vld), 32'(vecs[i].exp_bvld));
      chk($sformatf("vec%0d_req_rdy", i), 32'(fch_req_rdy), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_addr", i), ibus_req_addr, vecs[i].exp_addr);
      fch_req_vld = 1'b0; ibus_req_rdy = 1'b1;
      tick();
    end

    // Single fetch
    fch_req_vld = 1'b1; fch_req_pc = 32'h6;
    #1;
    chk("s1_addr", ibus_req_addr, 32'h4);
    chk("s1_ibus_vld", 32'(ibus_req_vld), 1);
    chk("s1_req_rdy", 32'(fch_req_rdy), 1);
    exp_q.push_back(32'h13);
    tick();
    fch_req_vld = 1'b0;
    chk("s1_live", 32'(dut.live_pend_q), 1);
    tick();
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'h13;
    #1;
    chk("s1_rsp_vld_pre", 32'(fch_rsp_vld), 0);
    tick();
    ibus_rsp_vld = 1'b0;
    chk("s1_rsp_vld", 32'(fch_rsp_vld), 1);
    chk("s1_rsp_ir", fch_rsp_ir, 32'h13);
    tick();
    chk("s1_rsp_vld_done", 32'(fch_rsp_vld), 0);
    chk("s1_fcnt", 32'(dut.fcnt_q), 0);
    chk("s1_live_done", 32'(dut.live_pend_q), 0);
    chk("s1_drop", 32'(dut.drop_cnt_q), 0);

    // Credit stall
    fch_rsp_rdy = 1'b0;
    fch_req_vld = 1'b1; fch_req_pc = 32'h200;
    #1;
    chk("s2_rdy0", 32'(fch_req_rdy), 1);
    exp_q.push_back(32'h11);
    tick();
    fch_req_pc = 32'h204;
    chk("s2_rdy1", 32'(fch_req_rdy), 1);
    exp_q.push_back(32'h22);
    tick();
    fch_req_pc = 32'h208;
    #1;
    chk("s2_rdy_full", 32'(fch_req_rdy), 0);
    chk("s2_ibus_vld_full", 32'(ibus_req_vld), 0);
    fch_req_vld = 1'b0;
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'h11;
    tick();
    ibus_rsp_data = 32'h22;
    chk("s2_rdy_one_buf", 32'(fch_req_rdy), 0);
    chk("s2_rsp_vld", 32'(fch_rsp_vld), 1);
    chk("s2_head", fch_rsp_ir, 32'h11);
    tick();
    ibus_rsp_vld = 1'b0;
    chk("s2_fcnt_full", 32'(dut.fcnt_q), 2);
    chk("s2_rdy_two_buf", 32'(fch_req_rdy), 0);
    fch_rsp_rdy = 1'b1;
    #1;
    chk("s2_rdy_pop_cycle", 32'(fch_req_rdy), 0);
    tick();
    chk("s2_rdy_after_pop", 32'(fch_req_rdy), 1);
    chk("s2_head2", fch_rsp_ir, 32'h22);
    tick();
    chk("s2_fcnt_empty", 32'(dut.fcnt_q), 0);

    // Flush with two reads in flight
    fch_req_vld = 1'b1; fch_req_pc = 32'h300;
    tick();
    fch_req_pc = 32'h304;
    tick();
    fch_req_pc = 32'h100; fl_req_vld = 1'b1;
    #1;
    chk("s3_rdy_flush", 32'(fch_req_rdy), 0);
    chk("s3_rsp_vld_flush", 32'(fch_rsp_vld), 0);
    tick();
    fl_req_vld = 1'b0;
    chk("s3_drop2", 32'(dut.drop_cnt_q), 2);
    chk("s3_live0", 32'(dut.live_pend_q), 0);
    chk("s3_rdy_post", 32'(fch_req_rdy), 1);
    exp_q.push_back(32'hCC);
    tick();
    fch_req_vld = 1'b0;
    chk("s3_live1", 32'(dut.live_pend_q), 1);
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'hAA;
    tick();
    chk("s3_drop1", 32'(dut.drop_cnt_q), 1);
    ibus_rsp_data = 32'hBB;
    tick();
    chk("s3_drop0", 32'(dut.drop_cnt_q), 0);
    chk("s3_no_rsp", 32'(fch_rsp_vld), 0);
    ibus_rsp_data = 32'hCC;
    tick();
    ibus_rsp_vld = 1'b0;
    chk("s3_rsp_vld", 32'(fch_rsp_vld), 1);
    chk("s3_rsp_ir", fch_rsp_ir, 32'hCC);
    tick();
    chk("s3_live_done", 32'(dut.live_pend_q), 0);

    // Flush with a buffered word
    fch_rsp_rdy = 1'b0;
    fch_req_vld = 1'b1; fch_req_pc = 32'h400;
    tick();
    fch_req_vld = 1'b0;
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'h44;
    tick();
    ibus_rsp_vld = 1'b0;
    chk("s4_buffered", 32'(fch_rsp_vld), 1);
    fch_rsp_rdy = 1'b1; fl_req_vld = 1'b1;
    #1;
    chk("s4_vld_flush", 32'(fch_rsp_vld), 0);
    tick();
    fl_req_vld = 1'b0;
    chk("s4_fcnt", 32'(dut.fcnt_q), 0);
    chk("s4_vld_after", 32'(fch_rsp_vld), 0);

    // Flush coincident with a live return
    fch_req_vld = 1'b1; fch_req_pc = 32'h500;
    tick();
    fch_req_vld = 1'b0;
    chk("s5_live1", 32'(dut.live_pend_q), 1);
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'h55; fl_req_vld = 1'b1;
    tick();
    ibus_rsp_vld = 1'b0; fl_req_vld = 1'b0;
    chk("s5_drop", 32'(dut.drop_cnt_q), 0);
    chk("s5_live", 32'(dut.live_pend_q), 0);
    chk("s5_fcnt", 32'(dut.fcnt_q), 0);

    // Fetch accepted in the flush cycle is live
    fch_req_vld = 1'b1; fch_req_pc = 32'h600;
    tick();
    fch_req_pc = 32'h700; fl_req_vld = 1'b1;
    #1;
    chk("s5b_rdy_flush", 32'(fch_req_rdy), 1);
    exp_q.push_back(32'h77);
    tick();
    fch_req_vld = 1'b0; fl_req_vld = 1'b0;
    chk("s5b_drop", 32'(dut.drop_cnt_q), 1);
    chk("s5b_live", 32'(dut.live_pend_q), 1);
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'h66;
    tick();
    chk("s5b_drop0", 32'(dut.drop_cnt_q), 0);
    chk("s5b_no_rsp", 32'(fch_rsp_vld), 0);
    ibus_rsp_data = 32'h77;
    tick();
    ibus_rsp_vld = 1'b0;
    chk("s5b_rsp_vld", 32'(fch_rsp_vld), 1);
    chk("s5b_rsp_ir", fch_rsp_ir, 32'h77);
    tick();

    // Reset mid-stream
    fch_rsp_rdy = 1'b0;
    fch_req_vld = 1'b1; fch_req_pc = 32'h800;
    tick();
    fch_req_pc = 32'h804;
    tick();
    fch_req_vld = 1'b0;
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'h88;
    tick();
    ibus_rsp_vld = 1'b0;
    chk("s6_fcnt_pre", 32'(dut.fcnt_q), 1);
    chk("s6_live_pre", 32'(dut.live_pend_q), 1);
    rst = 1'b1; fch_req_vld = 1'b1;
    #1;
    chk("s6_rst_req_rdy", 32'(fch_req_rdy), 0);
    chk("s6_rst_ibus_vld", 32'(ibus_req_vld), 0);
    chk("s6_rst_rsp_vld", 32'(fch_rsp_vld), 0);
    tick();
    rst = 1'b0; fch_req_vld = 1'b0;
    chk("s6_rsp_vld", 32'(fch_rsp_vld), 0);
    chk("s6_fcnt", 32'(dut.fcnt_q), 0);
    chk("s6_live", 32'(dut.live_pend_q), 0);
    chk("s6_drop", 32'(dut.drop_cnt_q), 0);
    fch_rsp_rdy = 1'b1;
    fch_req_vld = 1'b1; fch_req_pc = 32'h6;
    #1;
    chk("s6_addr", ibus_req_addr, 32'h4);
    exp_q.push_back(32'h13);
    tick();
    fch_req_vld = 1'b0;
    tick();
    ibus_rsp_vld = 1'b1; ibus_rsp_data = 32'h13;
    tick();
    ibus_rsp_vld = 1'b0;
    chk("s6_rsp_vld2", 32'(fch_rsp_vld), 1);
    chk("s6_rsp_ir", fch_rsp_ir, 32'h13);
    tick();
    chk("s6_live_done", 32'(dut.live_pend_q), 0);
    chk("s6_fcnt_done", 32'(dut.fcnt_q), 0);

    tick();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
